// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux4
// Purpose  : Registered 1-to-4 time-division demultiplexer. Each accepted
//            sample is steered to one of four output lanes. The lane comes
//            from an explicit select or from an internal round-robin counter.
//            A one-cycle frame_valid pulse is raised once all four lanes
//            have been refreshed.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   i_din,
  input  logic               i_din_valid,
  input  logic [1:0]         i_sel,
  input  logic               i_sel_en,
  input  logic               i_clr,
  output logic [4*WIDTH-1:0] o_y,
  output logic [3:0]         o_lane_valid,
  output logic               o_frame_valid,
  output logic               o_overrun,
  output logic [1:0]         o_cur_lane
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] c_ALL_LANES = 4'b1111;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_lane_valid;
  logic                 r_overrun;
  logic [1:0]           r_cur_lane;
  logic [4*WIDTH-1:0]   r_y;

  logic                 w_accept;
  logic [1:0]           w_tgt;
  logic [3:0]           w_tgt_oh;
  logic                 w_complete;
  logic                 w_dup;

  // Accept decode: clr wins over din_valid, target lane and frame events.
  always_comb begin
    w_accept   = i_din_valid & ~i_clr;
    w_tgt      = i_sel_en ? i_sel : r_cur_lane;
    w_tgt_oh   = 4'b0001 << w_tgt;
    w_complete = w_accept && ((r_lane_valid | w_tgt_oh) == c_ALL_LANES);
    w_dup      = w_accept && ((r_lane_valid & w_tgt_oh) != 4'b0000);
  end

  // Frame FSM next-state logic. DONE lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = w_complete ? ST_DONE : ST_FILL;
      ST_FILL:  if (w_complete) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = w_accept ? ST_FILL : ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
    if (i_clr) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Lane-valid bookkeeping; a completing write clears the set for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane_valid <= 4'b0000;
    end else if (i_clr) begin
      r_lane_valid <= 4'b0000;
    end else if (w_accept) begin
      r_lane_valid <= w_complete ? 4'b0000 : (r_lane_valid | w_tgt_oh);
    end
  end

  // Sticky overrun flag, set when a lane is rewritten inside one frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (i_clr) begin
      r_overrun <= 1'b0;
    end else if (w_dup) begin
      r_overrun <= 1'b1;
    end
  end

  // Round-robin counter advances only on accepts that use it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_lane <= 2'd0;
    end else if (i_clr) begin
      r_cur_lane <= 2'd0;
    end else if (w_accept && !i_sel_en) begin
      r_cur_lane <= r_cur_lane + 2'd1;
    end
  end

  generate
    for (genvar n = 0; n < 4; n++) begin : g_lane
      // Per-lane data register, loaded only when this lane is targeted.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_y[n*WIDTH +: WIDTH] <= '0;
        end else if (i_clr) begin
          r_y[n*WIDTH +: WIDTH] <= '0;
        end else if (w_accept && w_tgt_oh[n]) begin
          r_y[n*WIDTH +: WIDTH] <= i_din;
        end
      end
    end
  endgenerate

  assign o_y           = r_y;
  assign o_lane_valid  = r_lane_valid;
  assign o_frame_valid = (r_state == ST_DONE);
  assign o_overrun     = r_overrun;
  assign o_cur_lane    = r_cur_lane;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux4
// Purpose  : Directed self-checking bench for tdm_demux4 (WIDTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_valid;
  logic [1:0]  sel;
  logic        sel_en;
  logic        clr;
  logic [31:0] y;
  logic [3:0]  lane_valid;
  logic        frame_valid;
  logic        overrun;
  logic [1:0]  cur_lane;

  int checks = 0;
  int errors = 0;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_din         (din),
    .i_din_valid   (din_valid),
    .i_sel         (sel),
    .i_sel_en      (sel_en),
    .i_clr         (clr),
    .o_y           (y),
    .o_lane_valid  (lane_valid),
    .o_frame_valid (frame_valid),
    .o_overrun     (overrun),
    .o_cur_lane    (cur_lane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, pass one rising edge, land 1 time unit after it.
  task automatic cyc(input logic v, input logic [7:0] d, input logic se,
                     input logic [1:0] s, input logic c);
    din_valid = v;
    din       = d;
    sel_en    = se;
    sel       = s;
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ey, input logic [3:0] elv,
                         input logic efv, input logic eov, input logic [1:0] ecl);
    chk({tag, ".y"},  y, ey);
    chk({tag, ".lv"}, {28'd0, lane_valid}, {28'd0, elv});
    chk({tag, ".fv"}, {31'd0, frame_valid}, {31'd0, efv});
    chk({tag, ".ov"}, {31'd0, overrun}, {31'd0, eov});
    chk({tag, ".cl"}, {30'd0, cur_lane}, {30'd0, ecl});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset asserted with inputs toggling
    rst_n = 1'b0; din_valid = 1'b1; din = 8'hFF; sel_en = 1'b0; sel = 2'd3; clr = 1'b0;
    #2;
    chk_all("rst_imm", 32'h0, 4'b0000, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'(8'h5A + i), i[0], 2'(i), 1'b0);
      chk_all("rst_hold", 32'h0, 4'b0000, 1'b0, 1'b0, 2'd0);
    end
    rst_n = 1'b1;
    cyc(1'b0, 8'hCC, 1'b0, 2'd0, 1'b0);
    chk_all("rst_rel", 32'h0, 4'b0000, 1'b0, 1'b0, 2'd0);

    // 2: round-robin frame
    cyc(1'b1, 8'h11, 1'b0, 2'd0, 1'b0); chk_all("rr1", 32'h00000011, 4'b0001, 1'b0, 1'b0, 2'd1);
    cyc(1'b1, 8'h22, 1'b0, 2'd0, 1'b0); chk_all("rr2", 32'h00002211, 4'b0011, 1'b0, 1'b0, 2'd2);
    cyc(1'b1, 8'h33, 1'b0, 2'd0, 1'b0); chk_all("rr3", 32'h00332211, 4'b0111, 1'b0, 1'b0, 2'd3);
    cyc(1'b1, 8'h44, 1'b0, 2'd0, 1'b0); chk_all("rr4", 32'h44332211, 4'b0000, 1'b1, 1'b0, 2'd0);
    cyc(1'b0, 8'h99, 1'b0, 2'd0, 1'b0); chk_all("rr_idle", 32'h44332211, 4'b0000, 1'b0, 1'b0, 2'd0);

    // 3: explicit select with idle cycles interleaved
    cyc(1'b1, 8'hA3, 1'b1, 2'd3, 1'b0); chk_all("sel3", 32'hA3332211, 4'b1000, 1'b0, 1'b0, 2'd0);
    cyc(1'b0, 8'h00, 1'b1, 2'd0, 1'b0); chk_all("sel_i1", 32'hA3332211, 4'b1000, 1'b0, 1'b0, 2'd0);
    cyc(1'b1, 8'hA1, 1'b1, 2'd1, 1'b0); chk_all("sel1", 32'hA333A111, 4'b1010, 1'b0, 1'b0, 2'd0);
    cyc(1'b0, 8'h00, 1'b1, 2'd2, 1'b0); chk_all("sel_i2", 32'hA333A111, 4'b1010, 1'b0, 1'b0, 2'd0);
    cyc(1'b1, 8'hA0, 1'b1, 2'd0, 1'b0); chk_all("sel0", 32'hA333A1A0, 4'b1011, 1'b0, 1'b0, 2'd0);
    cyc(1'b1, 8'hA2, 1'b1, 2'd2, 1'b0); chk_all("sel2", 32'hA3A2A1A0, 4'b0000, 1'b1, 1'b0, 2'd0);
    cyc(1'b0, 8'h00, 1'b1, 2'd0, 1'b0); chk_all("sel_done", 32'hA3A2A1A0, 4'b0000, 1'b0, 1'b0, 2'd0);

    // 4: overrun on a duplicate lane write, cleared by clr
    cyc(1'b1, 8'h55, 1'b1, 2'd1, 1'b0); chk_all("ov1", 32'hA3A255A0, 4'b0010, 1'b0, 1'b0, 2'd0);
    cyc(1'b1, 8'h66, 1'b1, 2'd1, 1'b0); chk_all("ov2", 32'hA3A266A0, 4'b0010, 1'b0, 1'b1, 2'd0);
    cyc(1'b1, 8'h70, 1'b1, 2'd0, 1'b0); chk_all("ov3", 32'hA3A26670, 4'b0011, 1'b0, 1'b1, 2'd0);
    cyc(1'b1, 8'h72, 1'b1, 2'd2, 1'b0); chk_all("ov4", 32'hA3726670, 4'b0111, 1'b0, 1'b1, 2'd0);
    cyc(1'b1, 8'h73, 1'b1, 2'd3, 1'b0); chk_all("ov5", 32'h73726670, 4'b0000, 1'b1, 1'b1, 2'd0);
    cyc(1'b0, 8'h00, 1'b1, 2'd0, 1'b0); chk_all("ov_hold", 32'h73726670, 4'b0000, 1'b0, 1'b1, 2'd0);
    cyc(1'b0, 8'h00, 1'b1, 2'd0, 1'b1); chk_all("ov_clr", 32'h0, 4'b0000, 1'b0, 1'b0, 2'd0);

    // 5: clr together with din_valid drops the sample and restarts the counter
    cyc(1'b1, 8'hE1, 1'b0, 2'd0, 1'b0); chk_all("c1", 32'h000000E1, 4'b0001, 1'b0, 1'b0, 2'd1);
    cyc(1'b1, 8'hE2, 1'b0, 2'd0, 1'b0); chk_all("c2", 32'h0000E2E1, 4'b0011, 1'b0, 1'b0, 2'd2);
    cyc(1'b1, 8'hEE, 1'b0, 2'd0, 1'b1); chk_all("c_clr", 32'h0, 4'b0000, 1'b0, 1'b0, 2'd0);
    cyc(1'b1, 8'h01, 1'b0, 2'd0, 1'b0); chk_all("c3", 32'h00000001, 4'b0001, 1'b0, 1'b0, 2'd1);
    cyc(1'b1, 8'h02, 1'b0, 2'd0, 1'b0); chk_all("c4", 32'h00000201, 4'b0011, 1'b0, 1'b0, 2'd2);
    cyc(1'b1, 8'h03, 1'b0, 2'd0, 1'b0); chk_all("c5", 32'h00030201, 4'b0111, 1'b0, 1'b0, 2'd3);
    cyc(1'b1, 8'h04, 1'b0, 2'd0, 1'b0); chk_all("c6", 32'h04030201, 4'b0000, 1'b1, 1'b0, 2'd0);
    cyc(1'b0, 8'h00, 1'b0, 2'd0, 1'b0); chk_all("c_idle", 32'h04030201, 4'b0000, 1'b0, 1'b0, 2'd0);

    // 6: 12 back-to-back samples, frame_valid on every 4th
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 1'b0, 2'd0, 1'b0);
      chk("b2b.fv", {31'd0, frame_valid}, {31'd0, ((i % 4) == 3)});
      chk("b2b.cl", {30'd0, cur_lane}, 32'((i + 1) % 4));
    end
    chk("b2b.y", y, 32'h1B1A1918);
    chk("b2b.ov", {31'd0, overrun}, 32'd0);

    // 6b: asynchronous reset mid-frame
    cyc(1'b1, 8'h21, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 2'd0, 1'b0); chk_all("mid", 32'h1B1A2221, 4'b0011, 1'b0, 1'b0, 2'd2);
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all("mid_rst", 32'h0, 4'b0000, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    cyc(1'b1, 8'h31, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 8'h32, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 2'd0, 1'b0); chk_all("new3", 32'h00333231, 4'b0111, 1'b0, 1'b0, 2'd3);
    cyc(1'b1, 8'h34, 1'b0, 2'd0, 1'b0); chk_all("new4", 32'h34333231, 4'b0000, 1'b1, 1'b0, 2'd0);
    cyc(1'b0, 8'h00, 1'b0, 2'd0, 1'b0); chk_all("new_idle", 32'h34333231, 4'b0000, 1'b0, 1'b0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Registered 1-to-4 time-division demultiplexer. It is the receive-side counterpart of the 4:1 lane selector.
- Takes one sample stream and steers each accepted sample into one of four output lanes. Steering follows either an explicit lane select or an internal round-robin counter.
- Reports a one-cycle frame_valid pulse once all four lanes have been refreshed.
- Sits between a serialised TDM link and four-lane parallel consumers.

Parameters:
WIDTH, 8, bit width of each sample and of each output lane.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
din  input  WIDTH  incoming sample
din_valid  input  1  sample accepted on any rising edge where din_valid=1 (no backpressure)
sel  input  2  explicit target lane, used only when sel_en=1
sel_en  input  1  1: lane = sel; 0: lane = internal round-robin counter
clr  input  1  synchronous clear of the frame state
y  output  4*WIDTH  lane n occupies bits [n*WIDTH +: WIDTH]
lane_valid  output  4  bit n set = lane n written in the current frame
frame_valid  output  1  one-cycle pulse: frame completed on the previous edge
overrun  output  1  sticky: a lane was written twice within one frame
cur_lane  output  2  current round-robin counter value

Behaviour:
- Reset (rst_n=0, takes effect immediately regardless of clk):
  - y=0, lane_valid=0000, frame_valid=0, overrun=0, cur_lane=0, FSM=EMPTY.
  - Reset mid-frame discards all partial frame state.
- Target lane on an accept cycle: tgt = sel_en ? sel : cur_lane.
- Accept (din_valid=1, clr=0): on the edge,
  - y[tgt] <= din; latency is 1 cycle from the accept edge to visible data.
  - Other lanes hold.
- Round-robin counter:
  - cur_lane increments by 1 on each accept with sel_en=0, wrapping 3->0.
  - It holds when sel_en=1 or no accept.
  - Switching sel_en mid-frame is legal; the counter resumes from its held value.
- Overrun:
  - If an accept targets a lane whose lane_valid bit is already 1, overrun is set (sticky).
  - The data is still written.
  - The frame does not complete on that write.
- Frame completion:
  - Occurs when (lane_valid | onehot(tgt)) == 1111 on an accept edge.
  - On that edge: lane_valid <= 0000 and frame_valid <= 1.
  - frame_valid drops on the following edge, unconditionally.
  - Lanes 0-3 of y hold the complete frame until overwritten.
- FSM (explicit state register):
  - EMPTY: lane_valid=0000. Accept -> FILL, or DONE if the completion condition is met (impossible in a single accept).
  - FILL: ≥1 lane valid. Accept that completes -> DONE; otherwise stays in FILL.
  - DONE: one cycle, frame_valid=1, lane_valid=0000.
    - Accept in DONE starts a new frame -> FILL; no overrun is possible.
    - No accept -> EMPTY.
- clr (synchronous) has priority over din_valid:
  - lane_valid=0000, cur_lane=0, overrun=0, frame_valid=0, FSM=EMPTY, y=0.
  - The sample presented with clr is dropped.
- No-accept cycles: all state holds except the frame_valid self-clear and DONE->EMPTY.
- Throughput: one sample per cycle sustained. Back-to-back frames give frame_valid every 4 cycles with no gap.

Test Plan:
1. Assert rst_n=0 with arbitrary inputs toggling -> all outputs 0 immediately; release -> still 0 until first accept.
2. WIDTH=8, sel_en=0, din_valid on 4 consecutive cycles with 0x11,0x22,0x33,0x44 -> after 4th edge:
   - y=0x44332211, frame_valid=1 for exactly one cycle, lane_valid=0000.
   - cur_lane sequence 1,2,3,0.
3. sel_en=1, sel=3,1,0,2 with 0xA3,0xA1,0xA0,0xA2, idle cycles interleaved -> lane_valid 1000,1010,1011, then frame_valid pulse; y=0xA3A2A1A0.
4. sel_en=1, write lane 1 twice (0x55 then 0x66) then lanes 0,2,3 -> overrun=1 from the second write and stays 1; y lane1=0x66; frame_valid after the lane-3 write; clr -> overrun=0.
5. Round-robin: 2 samples, then clr together with din_valid, then 4 samples 0x01..0x04 -> y=0x04030201, the clr-cycle sample is absent, cur_lane restarts at 0.
6. Continuous din_valid for 12 cycles, sel_en=0 -> frame_valid high on cycles 4, 8 and 12 only. Then rst_n pulsed low mid-frame -> immediate clear; the next frame needs 4 fresh samples.
